// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches awaiting resolution; produces registered
// predictor-training and mispredict outputs. Define BRQ_STATS_EN to add resolve/mispredict counters.
module branch_resolve_queue #(
   parameter int PC_WIDTH = 32,
   parameter int DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enq_valid,
   input  logic [PC_WIDTH-1:0]        enq_pc,
   input  logic                       enq_pred_taken,
   output logic                       enq_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   input  logic                       flush,
   output logic [PC_WIDTH-1:0]        pc_check,
   output logic                       is_br_check,
   output logic                       br_taken_check,
   output logic                       mispredict,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       underflow_err
`ifdef BRQ_STATS_EN
   ,
   output logic [31:0]                stat_resolved,
   output logic [31:0]                stat_mispredicts
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];
   logic                pred_mem_q [DEPTH];

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q,  count_d;

   logic [PC_WIDTH-1:0] pc_check_q,       pc_check_d;
   logic                is_br_check_q,    is_br_check_d;
   logic                br_taken_check_q, br_taken_check_d;
   logic                mispredict_q,     mispredict_d;
   logic                underflow_q,      underflow_d;

   logic                full_s;
   logic                empty_s;
   logic                res_accept_s;
   logic                mispredict_now_s;
   logic                enq_fire_s;
   logic                clear_s;
   logic [PC_WIDTH-1:0] head_pc_s;
   logic                head_pred_s;

   // Handshake qualification; full blocks enqueue even when a pop happens in the same cycle.
   always_comb begin
      full_s           = (count_q == CNT_W'(DEPTH));
      empty_s          = (count_q == {CNT_W{1'b0}});
      head_pc_s        = pc_mem_q[rd_ptr_q];
      head_pred_s      = pred_mem_q[rd_ptr_q];
      res_accept_s     = res_valid && !empty_s;
      mispredict_now_s = res_accept_s && (res_taken != head_pred_s);
      enq_fire_s       = enq_valid && !full_s && !flush && !mispredict_now_s;
      clear_s          = flush || mispredict_now_s;
   end

   // Pointer and occupancy next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_s) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (enq_fire_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (res_accept_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({enq_fire_s, res_accept_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Training outputs: strobe only on an accepted resolve, PC/outcome hold otherwise.
   always_comb begin
      pc_check_d       = pc_check_q;
      br_taken_check_d = br_taken_check_q;
      is_br_check_d    = res_accept_s;
      mispredict_d     = mispredict_now_s;
      if (res_accept_s) begin
         pc_check_d       = head_pc_s;
         br_taken_check_d = res_taken;
      end else begin
         pc_check_d       = pc_check_q;
         br_taken_check_d = br_taken_check_q;
      end
      if (res_valid && empty_s) begin
         underflow_d = 1'b1;
      end else begin
         underflow_d = underflow_q;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= {PC_WIDTH{1'b0}};
            pred_mem_q[i] <= 1'b0;
         end
      end else if (enq_fire_s) begin
         pc_mem_q[wr_ptr_q]   <= enq_pc;
         pred_mem_q[wr_ptr_q] <= enq_pred_taken;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q         <= {PTR_W{1'b0}};
         rd_ptr_q         <= {PTR_W{1'b0}};
         count_q          <= {CNT_W{1'b0}};
         pc_check_q       <= {PC_WIDTH{1'b0}};
         is_br_check_q    <= 1'b0;
         br_taken_check_q <= 1'b0;
         mispredict_q     <= 1'b0;
         underflow_q      <= 1'b0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         pc_check_q       <= pc_check_d;
         is_br_check_q    <= is_br_check_d;
         br_taken_check_q <= br_taken_check_d;
         mispredict_q     <= mispredict_d;
         underflow_q      <= underflow_d;
      end
   end

   assign enq_ready      = !full_s;
   assign pc_check       = pc_check_q;
   assign is_br_check    = is_br_check_q;
   assign br_taken_check = br_taken_check_q;
   assign mispredict     = mispredict_q;
   assign count          = count_q;
   assign underflow_err  = underflow_q;

`ifdef BRQ_STATS_EN
   logic [31:0] stat_resolved_q,    stat_resolved_d;
   logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

   // Saturating event counters.
   always_comb begin
      if (res_accept_s && (stat_resolved_q != 32'hFFFF_FFFF)) begin
         stat_resolved_d = stat_resolved_q + 32'd1;
      end else begin
         stat_resolved_d = stat_resolved_q;
      end
      if (mispredict_now_s && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
         stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end else begin
         stat_mispredicts_d = stat_mispredicts_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_resolved_q    <= 32'd0;
         stat_mispredicts_q <= 32'd0;
      end else begin
         stat_resolved_q    <= stat_resolved_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_resolved    = stat_resolved_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=4, PC_WIDTH=32).
module tb_branch_resolve_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enq_valid;
   logic [31:0] enq_pc;
   logic        enq_pred_taken;
   logic        enq_ready;
   logic        res_valid;
   logic        res_taken;
   logic        flush;
   logic [31:0] pc_check;
   logic        is_br_check;
   logic        br_taken_check;
   logic        mispredict;
   logic [2:0]  count;
   logic        underflow_err;

   int total = 0;
   int bad   = 0;

   branch_resolve_queue #(.PC_WIDTH(32), .DEPTH(4)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enq_valid      (enq_valid),
      .enq_pc         (enq_pc),
      .enq_pred_taken (enq_pred_taken),
      .enq_ready      (enq_ready),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .flush          (flush),
      .pc_check       (pc_check),
      .is_br_check    (is_br_check),
      .br_taken_check (br_taken_check),
      .mispredict     (mispredict),
      .count          (count),
      .underflow_err  (underflow_err)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic ev, input logic [31:0] pc, input logic pt,
                        input logic rv, input logic rt, input logic fl);
      enq_valid = ev; enq_pc = pc; enq_pred_taken = pt;
      res_valid = rv; res_taken = rt; flush = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #12;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
      total++; if ({is_br_check, br_taken_check, mispredict, underflow_err} !== 4'b0000 || pc_check !== 32'h0)
         begin bad++; $display("FAIL reset_outputs got=%b%b%b%b pc=%h exp=0000 pc=0", is_br_check, br_taken_check, mispredict, underflow_err, pc_check); end
      @(posedge clk); #1 reset_n = 1'b1;
   endtask

   task automatic test_basic();
      drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0); step();
      total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", count); end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      total++; if (is_br_check !== 1'b1 || pc_check !== 32'h10 || br_taken_check !== 1'b1)
         begin bad++; $display("FAIL basic_train got=%b/%h/%b exp=1/00000010/1", is_br_check, pc_check, br_taken_check); end
      total++; if (mispredict !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL basic_mp_count got=%b/%0d exp=0/0", mispredict, count); end
      step();
      total++; if (is_br_check !== 1'b0 || pc_check !== 32'h10 || br_taken_check !== 1'b1)
         begin bad++; $display("FAIL basic_hold got=%b/%h/%b exp=0/00000010/1", is_br_check, pc_check, br_taken_check); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(4*i), 1'b1, 1'b0, 1'b0, 1'b0); step();
      end
      total++; if (count !== 3'd4 || enq_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=4/0", count, enq_ready); end
      drive(1'b1, 32'h110, 1'b1, 1'b0, 1'b0, 1'b0); step();
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_5th got=%0d exp=4", count); end
      drive(1'b1, 32'h114, 1'b1, 1'b1, 1'b1, 1'b0); step();
      total++; if (count !== 3'd3 || pc_check !== 32'h100) begin bad++; $display("FAIL full_nopass got=%0d/%h exp=3/00000100", count, pc_check); end
      for (int i = 1; i < 4; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); step();
         total++; if (pc_check !== 32'h100 + 32'(4*i) || is_br_check !== 1'b1)
            begin bad++; $display("FAIL full_drain%0d got=%h exp=%h", i, pc_check, 32'h100 + 32'(4*i)); end
      end
      total++; if (count !== 3'd0 || enq_ready !== 1'b1) begin bad++; $display("FAIL full_empty got=%0d/%b exp=0/1", count, enq_ready); end
   endtask

   task automatic test_mispredict();
      drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h28, 1'b1, 1'b1, 1'b1, 1'b0); step();
      total++; if (mispredict !== 1'b1 || pc_check !== 32'h20 || br_taken_check !== 1'b1)
         begin bad++; $display("FAIL mp_pulse got=%b/%h/%b exp=1/00000020/1", mispredict, pc_check, br_taken_check); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL mp_clear got=%0d exp=0", count); end
      step();
      total++; if (mispredict !== 1'b0 || is_br_check !== 1'b0) begin bad++; $display("FAIL mp_oneshot got=%b/%b exp=0/0", mispredict, is_br_check); end
      drive(1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      total++; if (pc_check !== 32'h30 || mispredict !== 1'b0) begin bad++; $display("FAIL mp_next got=%h/%b exp=00000030/0", pc_check, mispredict); end
   endtask

   task automatic test_underflow();
      total++; if (underflow_err !== 1'b0) begin bad++; $display("FAIL uf_pre got=%b exp=0", underflow_err); end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      total++; if (is_br_check !== 1'b0 || underflow_err !== 1'b1) begin bad++; $display("FAIL uf_set got=%b/%b exp=0/1", is_br_check, underflow_err); end
      drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0); step();
      total++; if (count !== 3'd1 || is_br_check !== 1'b0) begin bad++; $display("FAIL uf_nobypass got=%0d/%b exp=1/0", count, is_br_check); end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      step(); step();
      total++; if (pc_check !== 32'h40 || underflow_err !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%h/%b exp=00000040/1", pc_check, underflow_err); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (underflow_err !== 1'b0) begin bad++; $display("FAIL uf_reset got=%b exp=0", underflow_err); end
      @(posedge clk); #1 reset_n = 1'b1;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h50 + 32'(4*i), 1'b0, 1'b0, 1'b0, 1'b0); step();
      end
      drive(1'b1, 32'h5C, 1'b0, 1'b1, 1'b0, 1'b1); step();
      total++; if (is_br_check !== 1'b1 || pc_check !== 32'h50 || mispredict !== 1'b0 || count !== 3'd0)
         begin bad++; $display("FAIL flush_head got=%b/%h/%b/%0d exp=1/00000050/0/0", is_br_check, pc_check, mispredict, count); end
      drive(1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0); step();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      total++; if (pc_check !== 32'h60 || count !== 3'd0) begin bad++; $display("FAIL flush_after got=%h/%0d exp=00000060/0", pc_check, count); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h70 + 32'(4*i), 1'b1, 1'b0, 1'b0, 1'b0); step();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); step();
      total++; if (mispredict !== 1'b1 || is_br_check !== 1'b1) begin bad++; $display("FAIL rst_pre got=%b/%b exp=1/1", mispredict, is_br_check); end
      #2 reset_n = 1'b0;
      #1;
      total++; if ({is_br_check, br_taken_check, mispredict} !== 3'b000 || pc_check !== 32'h0 || count !== 3'd0 || enq_ready !== 1'b1)
         begin bad++; $display("FAIL rst_async got=%b%b%b/%h/%0d/%b exp=000/0/0/1", is_br_check, br_taken_check, mispredict, pc_check, count, enq_ready); end
      @(posedge clk); #1 reset_n = 1'b1;
      step();
      total++; if (is_br_check !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL rst_quiet got=%b/%0d exp=0/0", is_br_check, count); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_q[$];
      logic [31:0] exp_pc;
      logic [31:0] next_pc;
      next_pc = 32'h300;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, next_pc, 1'b1, 1'b0, 1'b0, 1'b0); exp_q.push_back(next_pc); next_pc += 32'h4; step();
      end
      for (int i = 0; i < 9; i++) begin
         if (i % 2 == 0) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); step();
            exp_pc = exp_q.pop_front();
            total++; if (pc_check !== exp_pc || is_br_check !== 1'b1)
               begin bad++; $display("FAIL wrap_order%0d got=%h exp=%h", i, pc_check, exp_pc); end
         end else begin
            drive(1'b1, next_pc, 1'b1, 1'b0, 1'b0, 1'b0); exp_q.push_back(next_pc); next_pc += 32'h4; step();
         end
      end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", count); end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); step();
      exp_pc = exp_q.pop_front();
      total++; if (pc_check !== exp_pc || count !== 3'd0) begin bad++; $display("FAIL wrap_last got=%h/%0d exp=%h/0", pc_check, count, exp_pc); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_mispredict();
      test_underflow();
      test_flush();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: width of every PC field.
REQ-002 SHALL have parameter DEPTH, default 4: number of in-flight branch entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port enq_valid  input  1: fetch presents a predicted branch.
REQ-006 SHALL have port enq_pc  input  PC_WIDTH: PC of that branch.
REQ-007 SHALL have port enq_pred_taken  input  1: br_pred_taken value from the predictor for that branch.
REQ-008 SHALL have port enq_ready  output  1: queue can accept an entry; equals !full, combinational.
REQ-009 SHALL have port res_valid  input  1: execute resolves the oldest outstanding branch.
REQ-010 SHALL have port res_taken  input  1: actual outcome of the resolved branch.
REQ-011 SHALL have port flush  input  1: external pipeline flush (trap or redirect); discards all entries.
REQ-012 SHALL have port pc_check  output  PC_WIDTH: registered PC sent to the predictor for training.
REQ-013 SHALL have port is_br_check  output  1: registered one-cycle training strobe.
REQ-014 SHALL have port br_taken_check  output  1: registered actual outcome for training.
REQ-015 SHALL have port mispredict  output  1: registered one-cycle pulse when the outcome differs from the prediction.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1: current occupancy.
REQ-017 SHALL have port underflow_err  output  1: sticky error flag.

Function
REQ-018 Enqueue SHALL occur at a rising edge when enq_valid && enq_ready && !flush && !mispredict_now; mispredict_now = res accepted && res_taken != head pred.
REQ-019 Resolve SHALL be accepted at a rising edge when res_valid && count != 0; the head entry is popped.
REQ-020 On accepted resolve, the next cycle SHALL show is_br_check=1, pc_check=head pc, br_taken_check=res_taken (one-cycle latency); otherwise is_br_check=0, and pc_check/br_taken_check hold their last values.
REQ-021 mispredict SHALL be 1 for exactly the cycle after an accepted resolve whose res_taken != stored prediction.
REQ-022 A mispredicting resolve SHALL clear all remaining entries (count=0 next cycle); an enqueue in the same cycle SHALL be dropped.
REQ-023 flush SHALL clear all entries next cycle and drop same-cycle enqueue; a same-cycle accepted resolve still emits its training and mispredict outputs.
REQ-024 When full, enq_ready SHALL be 0 even if a resolve pops in the same cycle (no pass-through).
REQ-025 When empty, enqueue and resolve in the same cycle SHALL NOT bypass: the entry is stored, the resolve is ignored, and underflow_err is set.
REQ-026 res_valid with count=0 SHALL set underflow_err, which is cleared only by reset.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; count SHALL change by +1, -1, 0, or go to 0 on clear.

Reset
REQ-028 While reset_n=0: count=0, pointers=0, is_br_check=0, br_taken_check=0, pc_check=0, mispredict=0, underflow_err=0, enq_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately; no training strobe is emitted for them.

Configuration
REQ-030 With macro BRQ_STATS_EN defined, the block SHALL add 32-bit outputs stat_resolved and stat_mispredicts, incremented per accepted resolve and per mispredict, saturating at 0xFFFFFFFF, and reset to 0.
REQ-031 Without BRQ_STATS_EN, those ports SHALL be absent and the block SHALL contain no counter logic.

Verification
REQ-032 Reset, then enq pc=0x10 pred=1, resolve taken=1 -> next cycle is_br_check=1, pc_check=0x10, br_taken_check=1, mispredict=0, count=0.
REQ-033 Enq 4 entries (DEPTH=4) -> enq_ready=0, count=4; a 5th enq_valid is not stored; resolve plus enq in the same cycle -> count=3.
REQ-034 Enq pcs 0x20 pred=0 and 0x24 pred=1, resolve taken=1 -> mispredict=1 for one cycle, pc_check=0x20, count=0; 0x24 is never trained.
REQ-035 Resolve while empty -> no is_br_check, underflow_err=1 and stays set until reset_n=0.
REQ-036 Enq 3 entries, assert flush with a correct resolve in the same cycle -> training for the head only, count=0; pull reset_n low mid-stream -> all outputs 0 asynchronously.
REQ-037 Run 2*DEPTH+1 alternating enq/resolve cycles -> pointers wrap and pc_check order matches enqueue order.
